fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- IF stage: owns the program counter, drives the instruction-memory address and loads the IF/ID pipeline register.
- Consumes the flush mask and jump_address produced by the EX-stage branch unit.
- Predicts taken jumps with a small direct-mapped branch target buffer (BTB), written on resolved redirects.
- Counts redirects for performance monitoring.

Parameters:
- BTB_ENTRIES, 16, number of BTB entries; power of two, at least 2.
- RESET_PC, 0, PC value loaded on reset.
- CNT_WIDTH, 16, width of the redirect counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  `NUM_PIPE_MASKS  flush mask from the branch unit; this block uses the `PIPE_REG_PC and `PIPE_REG_IF_ID bits.
- stall  in  `NUM_PIPE_MASKS  stall mask from the hazard unit; same bit encoding as flush.
- jump_address  in  `ADDR_WIDTH  redirect target from the branch unit.
- btb_write  in  1  write strobe for the BTB.
- btb_write_pc  in  `ADDR_WIDTH  PC of the resolved branch (BTB key).
- pc  out  `ADDR_WIDTH  current PC, the instruction-memory address.
- if_id_pc  out  `ADDR_WIDTH  PC captured into IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pred_taken  out  1  BTB hit at fetch.
- if_id_pred_target  out  `ADDR_WIDTH  predicted target; 0 when not taken.
- redirect_count  out  CNT_WIDTH  number of PC redirects since reset, saturating.

Behaviour:
- Reset (async assert, sync-release use):
  - pc = RESET_PC.
  - if_id_pc = 0, if_id_valid = 0, if_id_pred_taken = 0, if_id_pred_target = 0.
  - redirect_count = 0.
  - All BTB valid bits cleared.
  - Reset asserted mid-operation discards everything; nothing persists.
- BTB lookup, combinational on pc:
  - index = pc[log2(BTB_ENTRIES)-1:0]; tag = remaining upper bits.
  - hit = valid[index] and tag match; output is the stored target.
- Next PC, priority order:
  1. flush[`PIPE_REG_PC]: pc <= jump_address.
  2. Else stall[`PIPE_REG_PC]: pc holds.
  3. Else BTB hit: pc <= BTB target.
  4. Else pc <= pc + 1, wrapping modulo 2^`ADDR_WIDTH (all-ones to 0, no error).
- Redirect latency: flush asserted in cycle N means pc == jump_address in cycle N+1. A flush that is asserted simultaneously with stall still redirects; flush wins.
- IF/ID register, priority order:
  1. flush[`PIPE_REG_IF_ID]: if_id_valid <= 0, if_id_pred_taken <= 0, if_id_pc <= 0, if_id_pred_target <= 0.
  2. Else stall[`PIPE_REG_IF_ID]: all fields hold.
  3. Else capture pc, hit and target (target forced to 0 on miss); if_id_valid <= 1.
- BTB write:
  - On a rising edge with btb_write = 1: entry[index(btb_write_pc)] <= {valid=1, tag(btb_write_pc), jump_address}. The previous occupant is overwritten.
  - Same-cycle read of the same index returns the old contents; the new entry is visible next cycle.
  - Writes proceed regardless of stall.
- Redirect counter:
  - Increments by 1 on each edge where flush[`PIPE_REG_PC] = 1.
  - Saturates at all-ones; never wraps.
- Mask bits other than `PIPE_REG_PC and `PIPE_REG_IF_ID are ignored.
- No X propagation: every output register has a reset value.

Decomposition:
- Shared defines package (existing): `ADDR_WIDTH, `NUM_PIPE_MASKS and the `PIPE_REG_* bit masks. No new constants there.
- The log2 index-width function lives in the package if not already present.
- One sub-module: fetch_btb. Holds the direct-mapped valid/tag/target arrays, the combinational read port and the synchronous write port, with async-clear of valid bits.
- The next-PC mux, IF/ID register and redirect counter stay in fetch_unit.

Test Plan:
- Sequential fetch: release reset with RESET_PC=0, no stall/flush → pc = 0,1,2,3 on successive cycles; if_id_pc lags by one cycle; if_id_valid = 1 from the second cycle.
- Redirect: at pc=5, assert flush = `PIPE_REG_PC|`PIPE_REG_IF_ID with jump_address=0x40 → next cycle pc=0x40 and if_id_valid=0; following cycle if_id_pc=0x40, valid=1; redirect_count=1.
- Stall vs flush: hold stall[`PIPE_REG_PC]=1 for 3 cycles → pc frozen; assert flush with jump_address=0x20 while stall is still high → pc=0x20 next cycle.
- BTB prediction: btb_write=1, btb_write_pc=0x08, jump_address=0x30; later fetch reaches 0x08 → if_id_pred_taken=1, if_id_pred_target=0x30, next pc=0x30. An aliasing PC 0x18 (same index, different tag) → miss, next pc=0x19.
- Wrap and saturation:
  - pc=all-ones, no events → pc=0.
  - Force CNT_WIDTH=2 and issue 5 flushes → redirect_count=3.
- Mid-run reset: drop reset_n asynchronously between edges → pc=RESET_PC and if_id_valid=0 immediately; a previously written BTB entry no longer hits.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared pipeline defines (address width, pipe-mask bit positions) and the
// fetch-stage helper package.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 5
`endif
`ifndef PIPE_REG_PC
`define PIPE_REG_PC 0
`endif
`ifndef PIPE_REG_IF_ID
`define PIPE_REG_IF_ID 1
`endif
`ifndef PIPE_REG_ID_EX
`define PIPE_REG_ID_EX 2
`endif
`ifndef PIPE_REG_EX_MEM
`define PIPE_REG_EX_MEM 3
`endif
`ifndef PIPE_REG_MEM_WB
`define PIPE_REG_MEM_WB 4
`endif

package fetch_unit_pkg;

   // Number of index bits for a power-of-two table with n entries.
   function automatic int unsigned idx_width(input int unsigned n);
      int unsigned w;
      w = 32'd0;
      for (int unsigned i = 32'd0; i < 32'd31; i++) begin
         if ((32'd1 << i) < n) begin
            w = i + 32'd1;
         end else begin
            w = w;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous
// write, valid bits cleared by the asynchronous reset.
module fetch_btb
   import fetch_unit_pkg::*;
#(
   parameter int unsigned ENTRIES = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [`ADDR_WIDTH-1:0]  i_rd_pc,
   output logic                    o_hit,
   output logic [`ADDR_WIDTH-1:0]  o_target,
   input  logic                    i_wr_en,
   input  logic [`ADDR_WIDTH-1:0]  i_wr_pc,
   input  logic [`ADDR_WIDTH-1:0]  i_wr_target
);
   localparam int unsigned AW = `ADDR_WIDTH;
   localparam int unsigned IW = idx_width(ENTRIES);

   logic          r_valid  [ENTRIES];
   logic [AW-1:IW] r_tag   [ENTRIES];
   logic [AW-1:0] r_target [ENTRIES];

   logic [IW-1:0] w_rd_idx;
   logic [IW-1:0] w_wr_idx;

   assign w_rd_idx = i_rd_pc[IW-1:0];
   assign w_wr_idx = i_wr_pc[IW-1:0];

   // Lookup sees the pre-write contents; a same-cycle write lands next cycle.
   always_comb begin
      o_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == i_rd_pc[AW-1:IW]);
      o_target = r_target[w_rd_idx];
   end

   // Table storage with overwrite-on-write replacement.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= {(AW-IW){1'b0}};
            r_target[i] <= {AW{1'b0}};
         end
      end else if (i_wr_en) begin
         r_valid[w_wr_idx]  <= 1'b1;
         r_tag[w_wr_idx]    <= i_wr_pc[AW-1:IW];
         r_target[w_wr_idx] <= i_wr_target;
      end else begin
         r_valid[w_wr_idx] <= r_valid[w_wr_idx];
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: program counter with flush/stall/BTB-predicted next-PC selection,
// IF/ID pipeline register and a saturating redirect counter.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned                BTB_ENTRIES = 16,
   parameter logic [`ADDR_WIDTH-1:0]     RESET_PC    = {`ADDR_WIDTH{1'b0}},
   parameter int unsigned                CNT_WIDTH   = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [`NUM_PIPE_MASKS-1:0]  flush,
   input  logic [`NUM_PIPE_MASKS-1:0]  stall,
   input  logic [`ADDR_WIDTH-1:0]      jump_address,
   input  logic                        btb_write,
   input  logic [`ADDR_WIDTH-1:0]      btb_write_pc,
   output logic [`ADDR_WIDTH-1:0]      pc,
   output logic [`ADDR_WIDTH-1:0]      if_id_pc,
   output logic                        if_id_valid,
   output logic                        if_id_pred_taken,
   output logic [`ADDR_WIDTH-1:0]      if_id_pred_target,
   output logic [CNT_WIDTH-1:0]        redirect_count
);
   localparam int unsigned AW = `ADDR_WIDTH;

   logic [AW-1:0]        r_pc;
   logic [AW-1:0]        r_if_id_pc;
   logic                 r_if_id_valid;
   logic                 r_if_id_pred_taken;
   logic [AW-1:0]        r_if_id_pred_target;
   logic [CNT_WIDTH-1:0] r_redirect_count;

   logic          w_hit;
   logic [AW-1:0] w_btb_target;
   logic          w_flush_pc;
   logic          w_flush_if_id;
   logic          w_stall_pc;
   logic          w_stall_if_id;
   logic          w_unused_mask;

   assign w_flush_pc    = flush[`PIPE_REG_PC];
   assign w_flush_if_id = flush[`PIPE_REG_IF_ID];
   assign w_stall_pc    = stall[`PIPE_REG_PC];
   assign w_stall_if_id = stall[`PIPE_REG_IF_ID];
   // Other pipe-mask bits belong to later stages.
   assign w_unused_mask = ^{flush, stall};

   fetch_btb #(
      .ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_rd_pc     (r_pc),
      .o_hit       (w_hit),
      .o_target    (w_btb_target),
      .i_wr_en     (btb_write),
      .i_wr_pc     (btb_write_pc),
      .i_wr_target (jump_address)
   );

   // Next-PC selection: redirect beats stall beats prediction beats increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc <= RESET_PC;
      end else if (w_flush_pc) begin
         r_pc <= jump_address;
      end else if (w_stall_pc) begin
         r_pc <= r_pc;
      end else if (w_hit) begin
         r_pc <= w_btb_target;
      end else begin
         r_pc <= r_pc + {{(AW-1){1'b0}}, 1'b1};
      end
   end

   // IF/ID register; the predicted target is zeroed on a BTB miss.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_if_id_pc          <= {AW{1'b0}};
         r_if_id_valid       <= 1'b0;
         r_if_id_pred_taken  <= 1'b0;
         r_if_id_pred_target <= {AW{1'b0}};
      end else if (w_flush_if_id) begin
         r_if_id_pc          <= {AW{1'b0}};
         r_if_id_valid       <= 1'b0;
         r_if_id_pred_taken  <= 1'b0;
         r_if_id_pred_target <= {AW{1'b0}};
      end else if (w_stall_if_id) begin
         r_if_id_pc          <= r_if_id_pc;
         r_if_id_valid       <= r_if_id_valid;
         r_if_id_pred_taken  <= r_if_id_pred_taken;
         r_if_id_pred_target <= r_if_id_pred_target;
      end else begin
         r_if_id_pc          <= r_pc;
         r_if_id_valid       <= 1'b1;
         r_if_id_pred_taken  <= w_hit;
         r_if_id_pred_target <= w_hit ? w_btb_target : {AW{1'b0}};
      end
   end

   // Saturating count of PC redirects.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_redirect_count <= {CNT_WIDTH{1'b0}};
      end else if (w_flush_pc && (r_redirect_count != {CNT_WIDTH{1'b1}})) begin
         r_redirect_count <= r_redirect_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         r_redirect_count <= r_redirect_count;
      end
   end

   assign pc                = r_pc;
   assign if_id_pc          = r_if_id_pc;
   assign if_id_valid       = r_if_id_valid;
   assign if_id_pred_taken  = r_if_id_pred_taken;
   assign if_id_pred_target = r_if_id_pred_target;
   assign redirect_count    = r_redirect_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios then random traffic,
// checked against a behavioural fetch model; a second instance uses a 2-bit counter.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 5
`endif
`ifndef PIPE_REG_PC
`define PIPE_REG_PC 0
`endif
`ifndef PIPE_REG_IF_ID
`define PIPE_REG_IF_ID 1
`endif

module tb_fetch_unit;
   localparam int AW = `ADDR_WIDTH;
   localparam int NM = `NUM_PIPE_MASKS;
   localparam int NE = 16;

   typedef struct {
      logic [AW-1:0] pc;
      logic [AW-1:0] ifpc;
      logic          valid;
      logic          taken;
      logic [AW-1:0] target;
      logic [15:0]   cnt16;
      logic [1:0]    cnt2;
   } exp_t;

   logic          clk;
   logic          reset_n;
   logic [NM-1:0] flush;
   logic [NM-1:0] stall;
   logic [AW-1:0] jump_address;
   logic          btb_write;
   logic [AW-1:0] btb_write_pc;

   logic [AW-1:0] pc, if_id_pc, if_id_pred_target;
   logic          if_id_valid, if_id_pred_taken;
   logic [15:0]   redirect_count;
   logic [AW-1:0] pc_b, if_id_pc_b, if_id_pred_target_b;
   logic          if_id_valid_b, if_id_pred_taken_b;
   logic [1:0]    redirect_count_b;

   int total = 0;
   int bad   = 0;
   exp_t exp_q[$];

   // behavioural model state
   logic [AW-1:0] m_pc, m_ifpc, m_target;
   logic          m_valid, m_taken;
   int            m_cnt16, m_cnt2;
   bit            b_valid [NE];
   int            b_tag   [NE];
   logic [AW-1:0] b_tgt   [NE];

   fetch_unit #(.BTB_ENTRIES(NE), .RESET_PC(16'h0000), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .stall(stall),
      .jump_address(jump_address), .btb_write(btb_write), .btb_write_pc(btb_write_pc),
      .pc(pc), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
      .if_id_pred_taken(if_id_pred_taken), .if_id_pred_target(if_id_pred_target),
      .redirect_count(redirect_count));

   fetch_unit #(.BTB_ENTRIES(NE), .RESET_PC(16'h0000), .CNT_WIDTH(2)) dut_sat (
      .clk(clk), .reset_n(reset_n), .flush(flush), .stall(stall),
      .jump_address(jump_address), .btb_write(btb_write), .btb_write_pc(btb_write_pc),
      .pc(pc_b), .if_id_pc(if_id_pc_b), .if_id_valid(if_id_valid_b),
      .if_id_pred_taken(if_id_pred_taken_b), .if_id_pred_target(if_id_pred_target_b),
      .redirect_count(redirect_count_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_all(input exp_t e, input string tag);
      chk({tag, ".pc"},        32'(pc),                e.pc);
      chk({tag, ".if_id_pc"},  32'(if_id_pc),          e.ifpc);
      chk({tag, ".valid"},     32'(if_id_valid),       32'(e.valid));
      chk({tag, ".taken"},     32'(if_id_pred_taken),  32'(e.taken));
      chk({tag, ".target"},    32'(if_id_pred_target), e.target);
      chk({tag, ".cnt16"},     32'(redirect_count),    32'(e.cnt16));
      chk({tag, ".cnt2"},      32'(redirect_count_b),  32'(e.cnt2));
      chk({tag, ".pc_b"},      32'(pc_b),              e.pc);
   endtask

   function automatic exp_t cur_exp();
      exp_t e;
      e.pc = m_pc; e.ifpc = m_ifpc; e.valid = m_valid; e.taken = m_taken;
      e.target = m_target; e.cnt16 = 16'(m_cnt16); e.cnt2 = 2'(m_cnt2);
      return e;
   endfunction

   task automatic model_reset();
      m_pc = '0; m_ifpc = '0; m_valid = 1'b0; m_taken = 1'b0; m_target = '0;
      m_cnt16 = 0; m_cnt2 = 0;
      for (int i = 0; i < NE; i++) b_valid[i] = 1'b0;
   endtask

   // One clock edge of the fetch stage, written from the behavioural rules.
   task automatic model_step(input logic [NM-1:0] fl, input logic [NM-1:0] st,
                             input logic [AW-1:0] ja, input logic bw, input logic [AW-1:0] bwpc);
      int idx, tag, widx;
      bit hit;
      logic [AW-1:0] tgt, next_pc;
      idx = int'(m_pc) % NE;
      tag = int'(m_pc) / NE;
      hit = b_valid[idx] && (b_tag[idx] == tag);
      tgt = b_tgt[idx];
      if (fl[`PIPE_REG_PC])      next_pc = ja;
      else if (st[`PIPE_REG_PC]) next_pc = m_pc;
      else if (hit)              next_pc = tgt;
      else                       next_pc = AW'((int'(m_pc) + 1) % (1 << AW));
      if (fl[`PIPE_REG_IF_ID]) begin
         m_ifpc = '0; m_valid = 1'b0; m_taken = 1'b0; m_target = '0;
      end else if (!st[`PIPE_REG_IF_ID]) begin
         m_ifpc = m_pc; m_valid = 1'b1; m_taken = hit; m_target = hit ? tgt : '0;
      end
      if (fl[`PIPE_REG_PC]) begin
         if (m_cnt16 < 65535) m_cnt16++;
         if (m_cnt2 < 3) m_cnt2++;
      end
      if (bw) begin
         widx = int'(bwpc) % NE;
         b_valid[widx] = 1'b1;
         b_tag[widx]   = int'(bwpc) / NE;
         b_tgt[widx]   = ja;
      end
      m_pc = next_pc;
   endtask

   task automatic step(input logic [NM-1:0] fl, input logic [NM-1:0] st,
                       input logic [AW-1:0] ja, input logic bw, input logic [AW-1:0] bwpc);
      @(negedge clk);
      reset_n = 1'b1;
      flush = fl; stall = st; jump_address = ja; btb_write = bw; btb_write_pc = bwpc;
      model_step(fl, st, ja, bw, bwpc);
      exp_q.push_back(cur_exp());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0, '0);
   endtask

   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      flush = '0; stall = '0; jump_address = '0; btb_write = 1'b0; btb_write_pc = '0;
      model_reset();
      #1;
      check_all(cur_exp(), tag);
      @(negedge clk);
      exp_q.push_back(cur_exp());
   endtask

   // Monitor: one expectation per rising edge, compared just after it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_all(e, "edge");
         end
      end
   end

   localparam logic [NM-1:0] F_PC  = NM'(1) << `PIPE_REG_PC;
   localparam logic [NM-1:0] F_IF  = NM'(1) << `PIPE_REG_IF_ID;

   initial begin
      int guard;
      logic [NM-1:0] fl, st;
      reset_n = 1'b1;
      flush = '0; stall = '0; jump_address = '0; btb_write = 1'b0; btb_write_pc = '0;
      #2;
      do_reset("reset");

      idle(4);
      guard = 0;
      while (m_pc != 16'd5 && guard < 20) begin
         idle(1);
         guard++;
      end
      chk("reach_pc5", 32'(m_pc), 32'd5);
      step(F_PC | F_IF, '0, 16'h0040, 1'b0, '0);
      idle(2);

      step('0, F_PC, '0, 1'b0, '0);
      step('0, F_PC, '0, 1'b0, '0);
      step('0, F_PC, '0, 1'b0, '0);
      step(F_PC, F_PC, 16'h0020, 1'b0, '0);
      idle(1);

      step('0, '0, 16'h0030, 1'b1, 16'h0008);
      step(F_PC | F_IF, '0, 16'h0006, 1'b0, '0);
      idle(5);
      step(F_PC | F_IF, '0, 16'h0018, 1'b0, '0);
      idle(3);

      step(F_PC, '0, 16'hFFFF, 1'b0, '0);
      idle(2);
      for (int i = 0; i < 5; i++) step(F_PC, '0, 16'h0010, 1'b0, '0);
      idle(1);

      @(posedge clk);
      #3;
      do_reset("async_reset");
      step(F_PC | F_IF, '0, 16'h0008, 1'b0, '0);
      idle(3);

      for (int i = 0; i < 600; i++) begin
         fl = ($urandom_range(0, 7) == 0) ? NM'($urandom) : '0;
         st = ($urandom_range(0, 3) == 0) ? NM'($urandom) : '0;
         step(fl, st,
              ($urandom_range(0, 15) == 0) ? AW'($urandom_range(16'hFFF8, 16'hFFFF))
                                           : AW'($urandom_range(0, 63)),
              ($urandom_range(0, 3) == 0),
              AW'($urandom_range(0, 63)));
      end
      idle(2);

      @(posedge clk);
      #3;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
